// File: rtl/pulse_stretcher.sv
// pulse_stretcher: stretches single-cycle events into fixed-width LED pulses with a fixed gap,
// queuing events that arrive mid-pulse and replaying them in order.
module pulse_stretcher #(
  parameter int ON_CYCLES  = 1000000,
  parameter int OFF_CYCLES = 1000000,
  parameter int PEND_W     = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              PULSE_IN,
  input  logic              CLR_OVF,
  output logic              LED_OUT,
  output logic              BUSY,
  output logic [PEND_W-1:0] PENDING,
  output logic              OVERFLOW
);
  localparam int MAX_C = ON_CYCLES > OFF_CYCLES ? ON_CYCLES : OFF_CYCLES;
  localparam int TW = MAX_C > 1 ? $clog2(MAX_C) : 1;
  localparam logic [TW-1:0] ON_LD = TW'(ON_CYCLES - 1);
  localparam logic [TW-1:0] OFF_LD = TW'(OFF_CYCLES - 1);
  typedef enum logic [1:0] {IDLE, ON, OFF} state_t;
  state_t state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [PEND_W-1:0] pend_q, pend_d;
  logic led_q, led_d, busy_q, busy_d, ovf_q, ovf_d;
  logic t_zero, full, inc, deq;
  // The OFF exit looks at the post-increment queue, so a strobe on the last gap cycle replays directly.
  always_comb begin
    t_zero = timer_q == '0;
    full = &pend_q;
    inc = PULSE_IN && state_q != IDLE;
    deq = state_q == OFF && t_zero && (pend_q != '0 || inc);
    state_d = state_q;
    timer_d = timer_q;
    if (state_q == IDLE && PULSE_IN) begin
      state_d = ON;
      timer_d = ON_LD;
    end else if (state_q == ON) begin
      state_d = t_zero ? OFF : ON;
      timer_d = t_zero ? OFF_LD : timer_q - 1'b1;
    end else if (state_q == OFF) begin
      state_d = deq ? ON : t_zero ? IDLE : OFF;
      timer_d = deq ? ON_LD : t_zero ? timer_q : timer_q - 1'b1;
    end
    led_d = state_d == ON;
    busy_d = state_d != IDLE;
    pend_d = (inc && !deq) ? (full ? pend_q : pend_q + 1'b1)
           : (!inc && deq) ? pend_q - 1'b1 : pend_q;
    ovf_d = (inc && !deq && full) ? 1'b1 : CLR_OVF ? 1'b0 : ovf_q;
  end
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      timer_q <= '0;
      pend_q <= '0;
      led_q <= 1'b0;
      busy_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      pend_q <= pend_d;
      led_q <= led_d;
      busy_q <= busy_d;
      ovf_q <= ovf_d;
    end
  end
  assign LED_OUT = led_q;
  assign BUSY = busy_q;
  assign PENDING = pend_q;
  assign OVERFLOW = ovf_q;
endmodule

// File: tb/tb_pulse_stretcher.sv
// tb_pulse_stretcher: table-driven check of pulse_stretcher with ON=4, OFF=3, PEND_W=2.
module tb_pulse_stretcher;
  logic clk = 1'b0, rst = 1'b1, pulse_in = 1'b0, clr_ovf = 1'b0;
  logic led_out, busy, overflow;
  logic [1:0] pending;
  int checks = 0, failures = 0;
  typedef struct {
    logic p, c, led, busy;
    logic [1:0] pend;
    logic ovf;
  } vec_t;
  vec_t tv[$];
  pulse_stretcher #(.ON_CYCLES(4), .OFF_CYCLES(3), .PEND_W(2)) dut (
    .CLK(clk), .RST(rst), .PULSE_IN(pulse_in), .CLR_OVF(clr_ovf),
    .LED_OUT(led_out), .BUSY(busy), .PENDING(pending), .OVERFLOW(overflow)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  function automatic void add(input int n, input logic p, c, led, bsy, input logic [1:0] pend, input logic ovf);
    for (int i = 0; i < n; i++) tv.push_back('{p, c, led, bsy, pend, ovf});
  endfunction
  initial begin
    // single strobe: 4 on, 3 off, idle
    add(1, 1, 0, 1, 1, 0, 0); add(3, 0, 0, 1, 1, 0, 0); add(3, 0, 0, 0, 1, 0, 0); add(1, 0, 0, 0, 0, 0, 0);
    // three strobes, two queued
    add(1, 1, 0, 1, 1, 0, 0); add(1, 1, 0, 1, 1, 1, 0); add(1, 1, 0, 1, 1, 2, 0); add(1, 0, 0, 1, 1, 2, 0);
    add(3, 0, 0, 0, 1, 2, 0); add(4, 0, 0, 1, 1, 1, 0); add(3, 0, 0, 0, 1, 1, 0);
    add(4, 0, 0, 1, 1, 0, 0); add(3, 0, 0, 0, 1, 0, 0); add(1, 0, 0, 0, 0, 0, 0);
    // five strobes: saturate at 3, overflow, four pulses, clear
    add(1, 1, 0, 1, 1, 0, 0); add(1, 1, 0, 1, 1, 1, 0); add(1, 1, 0, 1, 1, 2, 0); add(1, 1, 0, 1, 1, 3, 0);
    add(1, 1, 0, 0, 1, 3, 1); add(2, 0, 0, 0, 1, 3, 1);
    add(4, 0, 0, 1, 1, 2, 1); add(3, 0, 0, 0, 1, 2, 1); add(4, 0, 0, 1, 1, 1, 1); add(3, 0, 0, 0, 1, 1, 1);
    add(4, 0, 0, 1, 1, 0, 1); add(3, 0, 0, 0, 1, 0, 1); add(1, 0, 0, 0, 0, 0, 1); add(1, 0, 1, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0);
    // strobe on the final OFF cycle replays with no IDLE visit
    add(1, 1, 0, 1, 1, 0, 0); add(3, 0, 0, 1, 1, 0, 0); add(3, 0, 0, 0, 1, 0, 0);
    add(1, 1, 0, 1, 1, 0, 0); add(3, 0, 0, 1, 1, 0, 0); add(3, 0, 0, 0, 1, 0, 0); add(1, 0, 0, 0, 0, 0, 0);
    // strobe on the dequeue edge with one pending: count holds, no overflow
    add(1, 1, 0, 1, 1, 0, 0); add(1, 1, 0, 1, 1, 1, 0); add(2, 0, 0, 1, 1, 1, 0); add(3, 0, 0, 0, 1, 1, 0);
    add(1, 1, 0, 1, 1, 1, 0); add(3, 0, 0, 1, 1, 1, 0); add(3, 0, 0, 0, 1, 1, 0);
    add(4, 0, 0, 1, 1, 0, 0); add(3, 0, 0, 0, 1, 0, 0); add(1, 0, 0, 0, 0, 0, 0);
    #1;
    chk("reset_led", 4'(led_out), 0); chk("reset_busy", 4'(busy), 0);
    chk("reset_pend", 4'(pending), 0); chk("reset_ovf", 4'(overflow), 0);
    @(negedge clk); rst = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < tv.size(); i++) begin
      pulse_in = tv[i].p;
      clr_ovf = tv[i].c;
      @(posedge clk); #1;
      chk($sformatf("v%0d_led", i), 4'(led_out), 4'(tv[i].led));
      chk($sformatf("v%0d_busy", i), 4'(busy), 4'(tv[i].busy));
      chk($sformatf("v%0d_pend", i), 4'(pending), 4'(tv[i].pend));
      chk($sformatf("v%0d_ovf", i), 4'(overflow), 4'(tv[i].ovf));
    end
    pulse_in = 1'b0; clr_ovf = 1'b0;
    // async reset mid-ON with two pending
    pulse_in = 1'b1;
    repeat (3) @(posedge clk);
    #1 pulse_in = 1'b0;
    chk("pre_rst_pend", 4'(pending), 2); chk("pre_rst_led", 4'(led_out), 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_led", 4'(led_out), 0); chk("arst_busy", 4'(busy), 0); chk("arst_pend", 4'(pending), 0);
    #3 rst = 1'b0;
    pulse_in = 1'b1;
    @(posedge clk); #1 pulse_in = 1'b0;
    chk("post_rst_led", 4'(led_out), 1); chk("post_rst_busy", 4'(busy), 1); chk("post_rst_pend", 4'(pending), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
